// File: rtl/mipi_frame_monitor.sv
// Observes the deserializer dvo/lvo/fvo strobes and measures line width, frame height and frame count.
// Outputs registered one cycle after the input event. Observation only, so the pixel stream is never stalled.
module mipi_frame_monitor #(
  parameter int CNT_WIDTH = 16,
  parameter int ERR_BITS  = 4
) (
  input  logic                 img_clk,
  input  logic                 resetb,
  input  logic                 enable,
  input  logic                 dvo,
  input  logic                 lvo,
  input  logic                 fvo,
  input  logic                 clear_stats,
  input  logic [CNT_WIDTH-1:0] exp_width,
  input  logic [CNT_WIDTH-1:0] exp_height,
  output logic [CNT_WIDTH-1:0] meas_width,
  output logic [CNT_WIDTH-1:0] meas_height,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic                 frame_done,
  output logic                 frame_active,
  output logic [ERR_BITS-1:0]  err_flags
);

  typedef enum logic [1:0] {
    ST_DISARMED   = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_IN_FRAME   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_next;
  logic                 r_lvo_q;
  logic                 r_fvo_q;
  logic [CNT_WIDTH-1:0] r_pix_cnt;
  logic [CNT_WIDTH-1:0] r_line_cnt;
  logic [CNT_WIDTH-1:0] r_meas_width;
  logic [CNT_WIDTH-1:0] r_meas_height;
  logic [CNT_WIDTH-1:0] r_frame_count;
  logic                 r_frame_done;
  logic [ERR_BITS-1:0]  r_err;

  logic                 w_lvo_rise;
  logic                 w_lvo_fall;
  logic                 w_fvo_rise;
  logic                 w_fvo_fall;
  logic                 w_armed;
  logic                 w_in_frame;
  logic                 w_line_end;
  logic                 w_frame_end;
  logic                 w_frame_start;
  logic                 w_pix_inc;
  logic [CNT_WIDTH-1:0] w_pix_next;
  logic [CNT_WIDTH-1:0] w_line_next;
  logic [CNT_WIDTH-1:0] w_final_lines;
  logic [ERR_BITS-1:0]  w_err_new;

  assign w_lvo_rise    = lvo & ~r_lvo_q;
  assign w_lvo_fall    = ~lvo & r_lvo_q;
  assign w_fvo_rise    = fvo & ~r_fvo_q;
  assign w_fvo_fall    = ~fvo & r_fvo_q;

  // A low enable discards the current cycle's events immediately, not only from next cycle.
  assign w_armed       = enable & (r_state != ST_DISARMED);
  assign w_in_frame    = enable & (r_state == ST_IN_FRAME);
  assign w_frame_start = enable & (r_state == ST_WAIT_FRAME) & w_fvo_rise;
  assign w_line_end    = w_in_frame & w_lvo_fall;
  assign w_frame_end   = w_in_frame & w_fvo_fall;

  assign w_pix_inc     = w_in_frame & ~w_lvo_rise & dvo & lvo & ~(&r_pix_cnt);
  assign w_pix_next    = r_pix_cnt + ONE;
  assign w_line_next   = (&r_line_cnt) ? r_line_cnt : (r_line_cnt + ONE);
  // A line closing in the same cycle as the frame is included in the height.
  assign w_final_lines = w_line_end ? w_line_next : r_line_cnt;

  always_comb begin
    w_err_new    = '0;
    w_err_new[0] = w_line_end & (exp_width != '0) & (r_pix_cnt != exp_width);
    w_err_new[1] = w_frame_end & (exp_height != '0) & (w_final_lines != exp_height);
    w_err_new[2] = w_armed & ((dvo & ~lvo) | (lvo & ~fvo) |
                              (w_lvo_rise & (r_state == ST_WAIT_FRAME)));
    w_err_new[3] = w_pix_inc & (&w_pix_next);
  end

  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) r_state <= ST_DISARMED;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_DISARMED:   w_next = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (w_fvo_rise) w_next = ST_IN_FRAME;
      ST_IN_FRAME:   if (w_fvo_fall) w_next = ST_WAIT_FRAME;
      default:       w_next = ST_DISARMED;
    endcase
    if (!enable) w_next = ST_DISARMED;
  end

  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      r_lvo_q       <= 1'b0;
      r_fvo_q       <= 1'b0;
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_meas_width  <= '0;
      r_meas_height <= '0;
      r_frame_count <= '0;
      r_frame_done  <= 1'b0;
      r_err         <= '0;
    end else begin
      // Edge history tracks the bus even when disarmed so a frame already open at arm time shows no rise.
      r_lvo_q <= lvo;
      r_fvo_q <= fvo;

      if (r_state == ST_DISARMED || w_frame_start) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= '0;
      end else if (w_in_frame) begin
        if (w_lvo_rise)     r_pix_cnt <= dvo ? ONE : '0;
        else if (w_pix_inc) r_pix_cnt <= w_pix_next;
        if (w_line_end)     r_line_cnt <= w_line_next;
      end

      if (w_line_end)  r_meas_width  <= r_pix_cnt;
      if (w_frame_end) r_meas_height <= w_final_lines;
      r_frame_done <= w_frame_end;

      // New events land on top of a same-cycle clear.
      r_frame_count <= (clear_stats ? '0 : r_frame_count) + (w_frame_end ? ONE : '0);
      r_err         <= (clear_stats ? '0 : r_err) | w_err_new;
    end
  end

  assign meas_width   = r_meas_width;
  assign meas_height  = r_meas_height;
  assign frame_count  = r_frame_count;
  assign frame_done   = r_frame_done;
  assign frame_active = (r_state == ST_IN_FRAME);
  assign err_flags    = r_err;

endmodule

// File: tb/tb_mipi_frame_monitor.sv
// Directed plus randomized frames against a frame-level reference model of the monitor.
// Narrow counters make pixel saturation reachable in a short run.
module tb_mipi_frame_monitor;

  localparam int W = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         img_clk = 1'b0;
  logic         resetb;
  logic         enable;
  logic         dvo;
  logic         lvo;
  logic         fvo;
  logic         clear_stats;
  logic [W-1:0] exp_width;
  logic [W-1:0] exp_height;
  logic [W-1:0] meas_width;
  logic [W-1:0] meas_height;
  logic [W-1:0] frame_count;
  logic         frame_done;
  logic         frame_active;
  logic [3:0]   err_flags;

  mipi_frame_monitor #(.CNT_WIDTH(W), .ERR_BITS(4)) dut (
    .img_clk(img_clk), .resetb(resetb), .enable(enable),
    .dvo(dvo), .lvo(lvo), .fvo(fvo), .clear_stats(clear_stats),
    .exp_width(exp_width), .exp_height(exp_height),
    .meas_width(meas_width), .meas_height(meas_height),
    .frame_count(frame_count), .frame_done(frame_done),
    .frame_active(frame_active), .err_flags(err_flags)
  );

  always #5 img_clk = ~img_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  // Reference model state: what the host should read back.
  int m_err, m_fc, m_mw, m_mh;
  int fw[8];

  always @(negedge img_clk) if (frame_done === 1'b1) n_done++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge img_clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".mw"},  32'(meas_width),  32'(m_mw));
    check({tag, ".mh"},  32'(meas_height), 32'(m_mh));
    check({tag, ".fc"},  32'(frame_count), 32'(m_fc));
    check({tag, ".err"}, 32'(err_flags),   32'(m_err));
  endtask

  task automatic model_reset();
    m_err = 0; m_fc = 0; m_mw = 0; m_mh = 0;
  endtask

  // Error bits a completed line of w pixels contributes; also updates expected width.
  function automatic int line_err(input int w);
    int sat;
    int e;
    sat = (w > MAXV) ? MAXV : w;
    e = 0;
    if (w >= MAXV) e |= 8;
    if (exp_width != 0 && sat != int'(exp_width)) e |= 1;
    m_mw = sat;
    return e;
  endfunction

  // Drives lvo high for npix valid pixels with random idle gaps; leaves lvo low for the caller's next tick.
  task automatic send_line(input int npix);
    lvo = 1'b1; dvo = 1'b1; tick();
    for (int p = 1; p < npix; p++) begin
      if ($urandom_range(3) == 0) begin
        dvo = 1'b0; tick();
      end
      dvo = 1'b1; tick();
    end
    dvo = 1'b0; lvo = 1'b0;
  endtask

  task automatic send_frame(input int nl, input bit coinc, input bit clr, input string tag);
    int e;
    int fin;
    fvo = 1'b1; tick();
    if ($urandom_range(1) == 1) tick();
    for (int l = 0; l < nl; l++) begin
      send_line(fw[l]);
      if (l == nl - 1 && coinc) break;
      tick();
      m_err |= line_err(fw[l]);
      if (l == 0) check({tag, ".active"}, 32'(frame_active), 32'd1);
      repeat ($urandom_range(2)) tick();
    end
    fvo = 1'b0; clear_stats = clr; tick(); clear_stats = 1'b0;
    fin = 0;
    if (coinc) begin
      e = line_err(fw[nl-1]);
      m_err |= (e & 8);
      fin |= (e & 1);
    end
    if (exp_height != 0 && nl != int'(exp_height)) fin |= 2;
    m_err = (clr ? 0 : m_err) | fin;
    m_fc  = clr ? 1 : (m_fc + 1) % (MAXV + 1);
    m_mh  = nl;
    check({tag, ".done"}, 32'(frame_done), 32'd1);
    check({tag, ".idle"}, 32'(frame_active), 32'd0);
    check_model(tag);
    tick();
    check({tag, ".done_end"}, 32'(frame_done), 32'd0);
  endtask

  task automatic inject_proto(input int kind);
    if (kind == 0) begin
      dvo = 1'b1; tick(); dvo = 1'b0; tick();
    end else begin
      lvo = 1'b1; tick(); lvo = 1'b0; tick();
    end
    m_err |= 4;
    check("proto.err", 32'(err_flags), 32'(m_err));
  endtask

  initial begin
    #5ms;
    n_fail++;
    $display("FAIL timeout");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    resetb = 1'b0; enable = 1'b0; dvo = 1'b0; lvo = 1'b0; fvo = 1'b0;
    clear_stats = 1'b0; exp_width = '0; exp_height = '0;
    model_reset();
    repeat (3) tick();
    check("rst.done", 32'(frame_done), 32'd0);
    check("rst.active", 32'(frame_active), 32'd0);
    check_model("rst");

    resetb = 1'b1; enable = 1'b1; exp_width = 4; exp_height = 3;
    tick();

    fw[0] = 4; fw[1] = 4; fw[2] = 4;
    send_frame(3, 1'b0, 1'b0, "good");

    fw[1] = 5;
    send_frame(3, 1'b0, 1'b0, "wide");
    fw[1] = 4;
    send_frame(3, 1'b0, 1'b0, "sticky1");
    send_frame(3, 1'b0, 1'b0, "sticky2");
    clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    m_err = 0; m_fc = 0;
    check_model("clear");

    send_frame(2, 1'b1, 1'b0, "coinc2");
    send_frame(3, 1'b1, 1'b0, "coinc3");

    // Arm while a frame is already open: it must not be counted.
    enable = 1'b0; tick();
    fvo = 1'b1; tick();
    send_line(4); tick();
    send_line(4); tick();
    d0 = n_done;
    enable = 1'b1; tick(); tick();
    fvo = 1'b0; tick(); tick();
    check("partial.done", 32'(n_done - d0), 32'd0);
    check_model("partial");
    send_frame(3, 1'b0, 1'b0, "after_partial");

    inject_proto(0);
    inject_proto(1);
    send_frame(3, 1'b0, 1'b1, "clr_frame");

    // Drop enable mid-line: the frame is discarded.
    fvo = 1'b1; tick();
    lvo = 1'b1; dvo = 1'b1; repeat (3) tick();
    d0 = n_done;
    enable = 1'b0; tick();
    lvo = 1'b0; dvo = 1'b0; tick();
    fvo = 1'b0; tick(); tick();
    check("drop.done", 32'(n_done - d0), 32'd0);
    check_model("drop");
    enable = 1'b1; tick();
    send_frame(3, 1'b0, 1'b0, "reenable");

    exp_width = 0; exp_height = 0;
    fw[0] = 300;
    send_frame(1, 1'b0, 1'b0, "sat");

    // Reset mid-line.
    exp_width = 4; exp_height = 3;
    fvo = 1'b1; tick();
    lvo = 1'b1; dvo = 1'b1; tick(); tick();
    resetb = 1'b0; tick();
    model_reset();
    check("midrst.done", 32'(frame_done), 32'd0);
    check("midrst.active", 32'(frame_active), 32'd0);
    check_model("midrst");
    lvo = 1'b0; dvo = 1'b0; fvo = 1'b0;
    resetb = 1'b1; tick();
    fw[0] = 4; fw[1] = 4; fw[2] = 4;
    send_frame(3, 1'b0, 1'b0, "postrst");

    for (int i = 0; i < 40; i++) begin
      int nl;
      exp_width  = ($urandom_range(3) == 0) ? 8'd0 : 8'd4;
      exp_height = ($urandom_range(3) == 0) ? 8'd0 : 8'd3;
      nl = $urandom_range(5, 1);
      for (int l = 0; l < nl; l++)
        fw[l] = ($urandom_range(2) == 0) ? $urandom_range(6, 1) : 4;
      send_frame(nl, 1'($urandom_range(1)), ($urandom_range(4) == 0), "rand");
      if ($urandom_range(5) == 0) inject_proto($urandom_range(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mipi_frame_monitor.md
Name: mipi_frame_monitor

Overview:
Downstream of the CSI-2 deserializer on img_clk. Consumes the registered pixel stream strobes (dvo, lvo, fvo) and measures frame geometry: pixels per line, lines per frame and frame count. Compares line and frame sizes against programmed expectations and raises sticky protocol and size error flags for host readout. Purely observational; the pixel data path is not modified.

Parameters:
CNT_WIDTH, 16, width of the pixel, line and frame counters and of the measured outputs.
ERR_BITS, 4, number of sticky error flags; fixed at 4.

Ports:
img_clk  in  1  pixel clock, same clock as the deserializer outputs
resetb  in  1  reset, asynchronous, active-low
enable  in  1  monitor enable; low forces ST_DISARMED
dvo  in  1  pixel valid from the deserializer
lvo  in  1  line valid from the deserializer
fvo  in  1  frame valid from the deserializer
clear_stats  in  1  one-cycle pulse; clears err_flags and frame_count
exp_width  in  CNT_WIDTH  expected pixels per line; 0 disables the width check
exp_height  in  CNT_WIDTH  expected lines per frame; 0 disables the height check
meas_width  out  CNT_WIDTH  pixel count of the last completed line
meas_height  out  CNT_WIDTH  line count of the last completed frame
frame_count  out  CNT_WIDTH  completed frames, wraps at 2^CNT_WIDTH
frame_done  out  1  one-cycle pulse when a frame completes
frame_active  out  1  high while in ST_IN_FRAME
err_flags  out  4  sticky: [0] width mismatch, [1] height mismatch, [2] protocol, [3] pixel counter saturated

Behaviour:
- Reset: all outputs 0; internal pix_cnt, line_cnt, lvo_q and fvo_q are 0; state ST_DISARMED.
- Edge detect uses registered lvo_q and fvo_q. lvo rise = lvo & !lvo_q. lvo fall = !lvo & lvo_q. fvo edges are formed the same way.
- Outputs are registered. An event seen on the inputs in cycle N is visible on the outputs in cycle N+1.
- State machine:
  - ST_DISARMED: entered while enable=0. Counters are held at 0 and no flags are set.
  - ST_DISARMED -> ST_WAIT_FRAME: on enable=1.
  - ST_WAIT_FRAME -> ST_IN_FRAME: on an fvo rise. pix_cnt and line_cnt clear to 0. An fvo that is already high when the monitor arms is ignored until it falls, so a partial frame is never counted.
  - ST_IN_FRAME -> ST_WAIT_FRAME: on an fvo fall.
  - enable=0 in any state -> ST_DISARMED next cycle. The in-progress frame is discarded: no frame_done, no meas update, no flags. err_flags and frame_count are retained.
- Counting in ST_IN_FRAME:
  - lvo rise: pix_cnt loads dvo (0 or 1).
  - Otherwise, when dvo & lvo: pix_cnt increments and saturates at all-ones. Reaching saturation sets err[3].
  - lvo fall: meas_width <= pix_cnt, line_cnt increments (saturating). Sets err[0] if exp_width != 0 and pix_cnt != exp_width.
- Frame end (fvo fall in ST_IN_FRAME):
  - meas_height <= final line count, frame_count increments (wrap), frame_done pulses for 1 cycle.
  - Sets err[1] if exp_height != 0 and the final line count != exp_height.
- Simultaneous lvo fall and fvo fall in the same cycle: the line is counted first. meas_height includes it, and both width and height checks apply in the same cycle.
- Protocol error err[2], only while not in ST_DISARMED:
  - dvo=1 with lvo=0.
  - lvo=1 with fvo=0.
  - lvo rise in ST_WAIT_FRAME.
- clear_stats: clears err_flags and frame_count. A new error or frame completion in the same cycle wins, so that flag or count is applied on top of the cleared value (frame_count becomes 1).
- frame_active = (state == ST_IN_FRAME), registered.
- Reset asserted mid-frame: immediate return to reset values. After release the monitor behaves as freshly armed.

Test Plan:
- exp_width=4, exp_height=3, enable=1. Send fvo frame of 3 lvo lines, 4 dvo pixels each -> frame_done 1-cycle pulse the cycle after fvo falls; meas_width=4, meas_height=3, frame_count=1, err_flags=0.
- Same settings, line 2 carries 5 pixels -> err_flags=4'b0001 after line 2 ends. It stays set through the next two good frames, then clears on clear_stats.
- exp_height=3, frame of 2 lines, with the last lvo fall in the same cycle as the fvo fall -> meas_height=2, err_flags[1]=1. Repeat with 3 lines ending coincident with fvo fall -> meas_height=3, no error.
- Raise enable while fvo is already high, mid-frame -> no frame_done and frame_count=0 at that frame's end. The next full frame gives frame_count=1.
- dvo pulse with lvo=0, then lvo high with fvo=0 -> err_flags[2]=1. Pulse clear_stats in the same cycle as a completing frame -> err_flags=0, frame_count=1.
- Drop enable mid-frame, then re-enable -> discarded frame leaves meas_* unchanged and frame_count unchanged. Assert resetb low mid-line -> all outputs 0 next cycle.
